// File: rtl/ct_add_arbiter_pkg.sv
// ct_add_arbiter_pkg
//   Shared types for the ciphertext modular-add arbiter.
//   - N_SLOTS_L / W_BITS_L : slots per polynomial and coefficient width
//   - vec_t                : one polynomial, N_SLOTS_L coefficients of W_BITS_L bits
//   - CT_t                 : ciphertext, polynomial pair (A, B)
//   - ct_add_state_e       : arbiter FSM states
package ct_add_arbiter_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;

  typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } CT_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ct_add_state_e;

endpackage

// File: rtl/ct_add_arbiter_if.sv
// ct_add_arbiter_if
//   Groups the request side and the result side of the arbiter.
//   Requester side : req_valid, req_ready (one-hot grant), req_ct1, req_ct2
//   Result side    : out_valid, out_ready, out_ct, out_id
//   modport slave  : the arbiter
//   modport master : the environment (issue logic and result buffer)
interface ct_add_arbiter_if
  import ct_add_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  CT_t  [NREQ-1:0] req_ct1;
  CT_t  [NREQ-1:0] req_ct2;

  logic            out_valid;
  logic            out_ready;
  CT_t             out_ct;
  logic [IDW-1:0]  out_id;

  modport slave (
    input  req_valid, req_ct1, req_ct2, out_ready,
    output req_ready, out_valid, out_ct, out_id
  );

  modport master (
    output req_valid, req_ct1, req_ct2, out_ready,
    input  req_ready, out_valid, out_ct, out_id
  );

endinterface

// File: rtl/ct_add_arbiter_mod_add_lane.sv
// ct_add_arbiter_mod_add_lane
//   Combinational single-coefficient modular add: r = (a + b) mod QP,
//   done as one conditional subtraction on the W+1 bit sum.
//   Ports: a, b (W bits, expected < QP), r (W bits).
module ct_add_arbiter_mod_add_lane #(
  parameter int          W  = 16,
  parameter logic [W-1:0] QP = 16'd7710
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  logic [W:0] sum;

  // Out-of-range operands get only this single subtraction, never a second one.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r   = (sum >= {1'b0, QP}) ? W'(sum - {1'b0, QP}) : W'(sum);
  end

endmodule

// File: rtl/ct_add_arbiter.sv
// ct_add_arbiter
//   Shares one ciphertext modular-add datapath between NREQ requesters.
//   A round-robin grant picks a requester in IDLE, both operand
//   ciphertexts are latched, then one slot of A and B is summed per cycle.
//   The finished ciphertext and requester id are held on out_valid/out_ready.
//   Ports:
//     clk, rst_n : clock (rising edge), async active-low reset
//     bus        : ct_add_arbiter_if.slave (request and result handshakes)
//     busy       : high whenever the FSM is not IDLE
module ct_add_arbiter
  import ct_add_arbiter_pkg::*;
#(
  parameter int           N    = N_SLOTS_L,
  parameter int           W    = W_BITS_L,
  parameter logic [W-1:0] QP   = 16'd7710,
  parameter int           NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ct_add_arbiter_if.slave   bus,
  output logic              busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = (N > 1) ? $clog2(N) : 1;

  ct_add_state_e  state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]  slot_q, slot_d;
  CT_t            ct1_q, ct1_d;
  CT_t            ct2_q, ct2_d;
  CT_t            out_ct_q, out_ct_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_valid_q, out_valid_d;

  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   sum_a;
  logic [W-1:0]   sum_b;

  // Requester index reached by stepping offset places past base, modulo NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int idx;
    idx = int'(base) + offset;
    if (idx >= NREQ) idx = idx - NREQ;
    return IDW'(idx);
  endfunction

  // Scan from the highest offset down so the nearest valid requester to
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_index(rr_ptr_q, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(rr_ptr_q, k);
      end
    end
  end

  // Grant is only offered in IDLE, so a handshake can never land mid-operation.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_valid) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  ct_add_arbiter_mod_add_lane #(.W(W), .QP(QP)) u_lane_a (
    .a (ct1_q.a[slot_q]),
    .b (ct2_q.a[slot_q]),
    .r (sum_a)
  );

  ct_add_arbiter_mod_add_lane #(.W(W), .QP(QP)) u_lane_b (
    .a (ct1_q.b[slot_q]),
    .b (ct2_q.b[slot_q]),
    .r (sum_b)
  );

  // Next-state logic; out_valid is set on the RUN->DONE edge so it comes
  // straight from a flop.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    slot_d      = slot_q;
    ct1_d       = ct1_q;
    ct2_d       = ct2_q;
    out_ct_d    = out_ct_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          ct1_d    = bus.req_ct1[grant_idx];
          ct2_d    = bus.req_ct2[grant_idx];
          out_id_d = grant_idx;
          slot_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        out_ct_d.a[slot_q] = sum_a;
        out_ct_d.b[slot_q] = sum_b;
        if (slot_q == SW'(N - 1)) begin
          slot_d      = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      DONE: begin
        // The requester just served drops to lowest priority.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = (out_id_q == IDW'(NREQ - 1)) ? '0 : out_id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears operands and partial sums as well as control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      slot_q      <= '0;
      ct1_q       <= '0;
      ct2_q       <= '0;
      out_ct_q    <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      slot_q      <= slot_d;
      ct1_q       <= ct1_d;
      ct2_q       <= ct2_d;
      out_ct_q    <= out_ct_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ct    = out_ct_q;
  assign bus.out_id    = out_id_q;
  assign busy          = (state_q != IDLE);

endmodule
